// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch-side, data-side and memory-side handshake
//            signals of the unified-memory port arbiter.
// Modports : master - arbiter view. It drives the memory request bus and
//                     returns data, valid pulses and stalls to the pipeline.
//            slave  - environment view (IF stage, MEM stage, memory macro).
// Signals  : if_req/if_addr/if_flush -> if_rdata/if_valid/if_stall
//            d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid/d_stall
//            mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  // data side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;
  // memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port unified memory between the IF-stage fetch
//            and the MEM-stage data access. Each transaction is sequenced with
//            a req/ack handshake to memory; read data is returned to the
//            winning requester with a one-cycle valid pulse, and the per-stage
//            stall signals are generated for the pipeline.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - mem_port_arbiter_if.master (fetch, data, memory buses)
// Params   : ADDR_W, DATA_W - address / data widths
//            MAX_D_BURST    - consecutive data grants before a waiting fetch
//                             is forced through (1..15, fairness build only)
// Options  : ARB_FAIRNESS_EN - when defined, enables the data-burst counter
//                              that periodically lets fetch win over data.
//                              Undefined: strict data priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MAX_D_BURST = 4
) (
  input wire                 clk,
  input wire                 rst_n,
  mem_port_arbiter_if.master bus
);

  if (MAX_D_BURST < 1 || MAX_D_BURST > 15) begin : g_max_d_burst_range
    $error("MAX_D_BURST must be within 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_d_valid;
  logic              r_drop;

  logic              w_grant_open;
  logic              w_d_pending;
  logic              w_f_pending;
  logic              w_force_fetch;
  logic              w_grant_d;
  logic              w_grant_f;

  // A valid pulse means the requester still shows the request it just had
  // served; it only updates req in the following cycle. Granting during the
  // valid cycle would replay a stale request, so arbitration waits one cycle.
  assign w_grant_open = (r_state == IDLE) && !r_if_valid && !r_d_valid;
  assign w_d_pending  = bus.d_req;
  assign w_f_pending  = bus.if_req && !bus.if_flush;

  assign w_grant_d = w_grant_open && w_d_pending && !w_force_fetch;
  assign w_grant_f = w_grant_open && w_f_pending && (!w_d_pending || w_force_fetch);

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] c_burst_limit = 4'(MAX_D_BURST);

  logic [3:0] r_burst_cnt;

  // Counts back-to-back data grants; saturates at the limit so a fetch that
  // shows up late still gets the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= 4'd0;
    end else if (w_grant_f) begin
      r_burst_cnt <= 4'd0;
    end else if (w_grant_d && (r_burst_cnt != c_burst_limit)) begin
      r_burst_cnt <= r_burst_cnt + 4'd1;
    end
  end

  assign w_force_fetch = w_f_pending && (r_burst_cnt == c_burst_limit);
`else
  assign w_force_fetch = 1'b0;
`endif

  // Main sequencer. The grant cycle only latches the request; mem_req rises
  // on the following cycle and an ack is honoured only while mem_req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_drop <= 1'b0;
          if (w_grant_d) begin
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_state     <= D_BUSY;
          end else if (w_grant_f) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr;
            r_state    <= F_BUSY;
          end
        end

        F_BUSY: begin
          if (bus.if_flush) begin
            r_drop <= 1'b1;
          end
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= IDLE;
            // A flush seen earlier or in the ack cycle itself kills the result.
            if (!r_drop && !bus.if_flush) begin
              r_if_rdata <= bus.mem_rdata;
              r_if_valid <= 1'b1;
            end
          end
        end

        D_BUSY: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            r_d_valid <= 1'b1;
            if (!r_mem_we) begin
              r_d_rdata <= bus.mem_rdata;
            end
          end
        end

        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;

  // Stalls hold while a request is outstanding and release in the valid cycle.
  assign bus.if_stall = bus.if_req & ~r_if_valid;
  assign bus.d_stall  = bus.d_req & ~r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural memory
//            answers the bus, a scoreboard queue per requester holds expected
//            return data, and a monitor pops and compares on each valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
  } txn_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] if_q[$];
  logic [15:0] d_q[$];
  txn_t        txn_log[$];

  logic [15:0] mem_array [logic [15:0]];
  logic [15:0] ref_mem   [logic [15:0]];
  logic [15:0] last_read;

  int ack_mode    = 0;   // 0: ack tied high, 1: fixed delay, 2: random delay
  int fixed_delay = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem_array.exists(a) ? mem_array[a] : init_val(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_valid(input bit fetch, input string name);
    int k;
    k = 0;
    forever begin
      sample();
      if (fetch ? bus.if_valid : bus.d_valid) break;
      k++;
      if (k > 200) begin
        fail_now(name);
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    last_read    = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue one data access and record the value the requester should see.
  task automatic issue_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    if (we) begin
      ref_mem[a] = wd;
    end else begin
      last_read = ref_read(a);
    end
    d_q.push_back(last_read);
  endtask

  function automatic logic [16:0] log_at(input int i);
    txn_t t;
    t = '1;
    if (i < txn_log.size()) t = txn_log[i];
    return t;
  endfunction

  // Memory macro: decides ack at each negedge for the coming edge.
  initial begin : mem_model
    int cnt;
    int dly;
    cnt = 0;
    dly = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!bus.mem_req) begin
        cnt = 0;
        bus.mem_ack = (ack_mode == 0);
      end else begin
        if (cnt == 0) dly = (ack_mode == 2) ? int'($urandom_range(0, 3)) :
                            (ack_mode == 1) ? fixed_delay : 0;
        bus.mem_ack = (cnt >= dly);
        cnt++;
        if (bus.mem_ack && bus.mem_we) mem_array[bus.mem_addr] = bus.mem_wdata;
      end
      bus.mem_rdata = mem_read(bus.mem_addr);
    end
  end

  // Monitor: grant log, request-hold protocol and scoreboard pops.
  initial begin : monitor
    logic        p_req, p_ack, p_we;
    logic [15:0] p_addr, p_wdata;
    txn_t        t;
    p_req = 1'b0;
    p_ack = 1'b0;
    p_we  = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        p_req = 1'b0;
        p_ack = 1'b0;
      end else begin
        if (bus.mem_req && !p_req) begin
          t.we   = bus.mem_we;
          t.addr = bus.mem_addr;
          txn_log.push_back(t);
        end
        if (p_req && !p_ack)
          check("mem_hold", {30'd0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                            {30'd0, 1'b1, p_we, p_addr, p_wdata});
        if (bus.if_valid) begin
          if (if_q.size() == 0) fail_now("if_valid_unexpected");
          else check("if_rdata", {48'd0, bus.if_rdata}, {48'd0, if_q.pop_front()});
        end
        if (bus.d_valid) begin
          if (d_q.size() == 0) fail_now("d_valid_unexpected");
          else check("d_rdata", {48'd0, bus.d_rdata}, {48'd0, d_q.pop_front()});
        end
        p_req   = bus.mem_req;
        p_ack   = bus.mem_ack;
        p_we    = bus.mem_we;
        p_addr  = bus.mem_addr;
        p_wdata = bus.mem_wdata;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic t_flush(input logic [15:0] a0, input logic [15:0] a1, input int fcyc, input int dly);
    int start;
    ack_mode    = 1;
    fixed_delay = dly;
    start = txn_log.size();
    step();
    bus.if_addr = a0;
    bus.if_req  = 1'b1;
    repeat (fcyc) step();
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    bus.if_addr  = a1;
    if_q.push_back(init_val(a1));
    wait_valid(1'b1, "flush_refetch_timeout");
    step();
    bus.if_req = 1'b0;
    check("flush_first_txn",  {47'd0, log_at(start)},     {47'd0, 1'b0, a0});
    check("flush_second_txn", {47'd0, log_at(start + 1)}, {47'd0, 1'b0, a1});
  endtask

  initial begin : main
    int    start;
    int    count;
    int    k;
    string order;

    do_reset();

    // Reset state
    sample();
    check("reset_outputs", {46'd0, bus.mem_req, bus.mem_we, bus.if_valid, bus.d_valid, bus.mem_addr},
                           64'd0);
    check("reset_data", {bus.mem_wdata, bus.if_rdata, bus.d_rdata, 16'd0}, 64'd0);

    // Best-case fetch latency with ack tied high
    ack_mode = 0;
    mem_array[16'h0010] = 16'hA5A5;
    step();
    bus.if_addr = 16'h0010;
    bus.if_req  = 1'b1;
    if_q.push_back(16'hA5A5);
    step(); sample();
    check("t1_c1_req_stall", {62'd0, bus.mem_req, bus.if_stall}, {62'd0, 2'b01});
    step(); sample();
    check("t1_c2_mem_req", {46'd0, bus.mem_req, bus.mem_we, bus.mem_addr}, {46'd0, 2'b10, 16'h0010});
    step(); sample();
    check("t1_c3_valid", {46'd0, bus.if_valid, bus.if_stall, bus.if_rdata}, {46'd0, 2'b10, 16'hA5A5});
    step();
    bus.if_req = 1'b0;
    step();

    // Simultaneous requests: data write first, fetch after d_valid
    start = txn_log.size();
    step();
    issue_data(1'b1, 16'h0200, 16'h1234);
    bus.if_addr = 16'h0020;
    bus.if_req  = 1'b1;
    if_q.push_back(init_val(16'h0020));
    fork
      begin wait_valid(1'b0, "t2_d_timeout"); step(); bus.d_req = 1'b0; end
      begin wait_valid(1'b1, "t2_if_timeout"); step(); bus.if_req = 1'b0; end
    join
    check("t2_first_is_write", {47'd0, log_at(start)},     {47'd0, 1'b1, 16'h0200});
    check("t2_then_fetch",     {47'd0, log_at(start + 1)}, {47'd0, 1'b0, 16'h0020});
    check("t2_mem_written",    {48'd0, mem_read(16'h0200)}, {48'd0, 16'h1234});

    // Flush during F_BUSY, then flush in the ack cycle itself
    t_flush(16'h0030, 16'h0040, 2, 4);
    t_flush(16'h0060, 16'h0070, 4, 2);

    // Reset while a data read is outstanding
    ack_mode    = 1;
    fixed_delay = 6;
    step();
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0300;
    bus.d_req  = 1'b1;
    step(); step(); step();
    check("t4_busy_before_reset", {63'd0, bus.mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t4_mem_req_async_drop", {63'd0, bus.mem_req}, 64'd0);
    bus.d_req = 1'b0;
    last_read = '0;
    step(); step();
    rst_n = 1'b1;
    repeat (6) begin
      sample();
      check("t4_quiet_after_reset", {62'd0, bus.d_valid, bus.mem_req}, 64'd0);
      step();
    end

    // Grant order with both requests held high
    do_reset();
    ack_mode = 0;
`ifdef ARB_FAIRNESS_EN
    order = "DDDDFD";
`else
    order = "DDDDDD";
`endif
    for (int i = 0; i < 6; i++) begin
      if (order[i] == "D") d_q.push_back(ref_read(16'h0150));
      else                 if_q.push_back(init_val(16'h0050));
    end
    last_read = ref_read(16'h0150);
    start = txn_log.size();
    step();
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0150;
    bus.d_req   = 1'b1;
    bus.if_addr = 16'h0050;
    bus.if_req  = 1'b1;
    count = 0;
    k = 0;
    while (count < 6 && k < 300) begin
      sample();
      if (bus.if_valid || bus.d_valid) count++;
      step();
      k++;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    if (count < 6) fail_now("t5_order_timeout");
    for (int i = 0; i < 6; i++)
      check("t5_grant_order", {47'd0, log_at(start + i)},
            {47'd0, 1'b0, (order[i] == "D") ? 16'h0150 : 16'h0050});
    repeat (4) step();
    check("t5_no_extra_grant", 64'(txn_log.size()), 64'(start + 6));

    // Long ack wait: request held stable, data stall asserted
    ack_mode    = 1;
    fixed_delay = 10;
    step();
    issue_data(1'b1, 16'h0180, 16'hBEEF);
    step(); step();
    repeat (10) begin
      sample();
      check("t6_hold_and_stall", {29'd0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.d_stall},
                                 {29'd0, 1'b1, 1'b1, 16'h0180, 16'hBEEF, 1'b1});
      step();
    end
    wait_valid(1'b0, "t6_timeout");
    step();
    bus.d_req = 1'b0;
    check("t6_mem_written", {48'd0, mem_read(16'h0180)}, {48'd0, 16'hBEEF});

    // Randomized concurrent traffic with random memory latency
    ack_mode = 2;
    fork
      begin : fetch_agent
        logic [15:0] a;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          a = 16'($urandom_range(0, 255));
          bus.if_addr = a;
          bus.if_req  = 1'b1;
          if_q.push_back(init_val(a));
          wait_valid(1'b1, "rand_if_timeout");
          step();
          bus.if_req = 1'b0;
        end
      end
      begin : data_agent
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) step();
          issue_data(1'($urandom_range(0, 1)), 16'(16'h0100 + $urandom_range(0, 255)), 16'($urandom));
          wait_valid(1'b0, "rand_d_timeout");
          step();
          bus.d_req = 1'b0;
        end
      end
    join

    repeat (8) step();
    check("scoreboard_drained", 64'(if_q.size() + d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
